lcd_row_streamer: RTL and testbench



---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_row_streamer_if.sv | 23 ++
 rtl/lcd_row_streamer_spi_byte_tx.sv | 64 ++++++
 rtl/lcd_row_streamer.sv | 136 +++++++++++++
 tb/tb_lcd_row_streamer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD row streamer: panel command bytes, streamer
// states, default panel geometry and the page-window byte generator.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int LCD_WIDTH  = 320;
    localparam int LCD_HEIGHT = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_PAGE,
        ST_CMD_RAMWR,
        ST_PIXELS,
        ST_FINISH
    } streamer_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } spi_byte_t;

    // Page window: PASET command, then start page and end page, both equal to the row.
    function automatic spi_byte_t page_byte(input logic [2:0] idx, input logic [8:0] y);
        spi_byte_t b;
        b.dc = (idx != 3'd0);
        case (idx)
            3'd0:       b.data = CMD_PASET;
            3'd1, 3'd3: b.data = {7'd0, y[8]};
            default:    b.data = y[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_row_streamer_if.sv
// Renderer/row-buffer/panel signals of the row streamer. The streamer is the
// slave side; the renderer (which also owns the row buffer) is the master.
interface lcd_row_streamer_if;
    logic        start;
    logic        busy;
    logic [8:0]  yCoord;
    logic [8:0]  readAddress;
    logic [15:0] readData;
    logic        lcdCsN;
    logic        lcdDc;
    logic        lcdSclk;
    logic        lcdMosi;

    modport master (
        output start, readData,
        input  busy, yCoord, readAddress, lcdCsN, lcdDc, lcdSclk, lcdMosi
    );

    modport slave (
        input  start, readData,
        output busy, yCoord, readAddress, lcdCsN, lcdDc, lcdSclk, lcdMosi
    );
endinterface

// File: rtl/lcd_row_streamer_spi_byte_tx.sv
// SPI mode-0 byte transmitter: MSB first, each bit cell is CLKDIV cycles low
// then CLKDIV cycles high, so a byte takes 16*CLKDIV cycles after load.
module spi_byte_tx #(
    parameter int CLKDIV = 2
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dc,
    output logic       ready,
    output logic       sclk,
    output logic       mosi,
    output logic       dcOut
);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    logic          active;
    logic [DW-1:0] divCnt;
    logic [2:0]    bitCnt;
    logic [6:0]    shiftReg;

    assign ready = ~active;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            active   <= 1'b0;
            divCnt   <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            dcOut    <= 1'b0;
        end else if (!active) begin
            if (load) begin
                active   <= 1'b1;
                divCnt   <= '0;
                bitCnt   <= '0;
                mosi     <= data[7];
                shiftReg <= data[6:0];
                dcOut    <= dc;
            end
        end else if (divCnt != DIV_LAST) begin
            divCnt <= divCnt + 1'b1;
        end else begin
            divCnt <= '0;
            if (!sclk) begin
                sclk <= 1'b1;
            end else begin
                // Falling edge closes a bit cell; the next bit goes out while SCLK is low.
                sclk <= 1'b0;
                if (bitCnt == 3'd7) begin
                    active <= 1'b0;
                end else begin
                    bitCnt   <= bitCnt + 3'd1;
                    mosi     <= shiftReg[6];
                    shiftReg <= {shiftReg[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/lcd_row_streamer.sv
// Streams one rendered row from the line buffer to an ILI9341-class panel:
// page window, memory write command, then WIDTH RGB565 pixels high byte first.
module lcd_row_streamer
    import lcd_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int HEIGHT = LCD_HEIGHT,
    parameter int CLKDIV = 2
) (
    input logic                clock,
    input logic                resetN,
    lcd_row_streamer_if.slave  bus
);
    localparam int            STAGES    = 1;
    localparam logic [8:0]    LAST_ADDR = 9'(WIDTH - 1);
    localparam logic [8:0]    LAST_ROW  = 9'(HEIGHT - 1);

    streamer_state_e state_q, state_d;

    logic            busyQ, csNQ;
    logic [8:0]      yQ, rdAddr;
    logic [2:0]      byteIdx;
    logic [15:0]     pixBuf;
    logic            pixFull, hiSent, lastSent;
    logic [STAGES:0] vld_pipe;

    spi_byte_t       txReq;
    logic            txLoad, txReady, issueRead;

    assign bus.busy        = busyQ;
    assign bus.lcdCsN      = csNQ;
    assign bus.yCoord      = yQ;
    assign bus.readAddress = rdAddr;

    spi_byte_tx #(.CLKDIV(CLKDIV)) u_tx (
        .clock  (clock),
        .resetN (resetN),
        .load   (txLoad),
        .data   (txReq.data),
        .dc     (txReq.dc),
        .ready  (txReady),
        .sclk   (bus.lcdSclk),
        .mosi   (bus.lcdMosi),
        .dcOut  (bus.lcdDc)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        txLoad    = 1'b0;
        txReq     = '0;
        issueRead = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CMD_PAGE;
            ST_CMD_PAGE: if (txReady) begin
                txLoad = 1'b1;
                txReq  = page_byte(byteIdx, yQ);
                if (byteIdx == 3'd4) state_d = ST_CMD_RAMWR;
            end
            ST_CMD_RAMWR: if (txReady) begin
                txLoad     = 1'b1;
                txReq.data = CMD_RAMWR;
                issueRead  = 1'b1;
                state_d    = ST_PIXELS;
            end
            ST_PIXELS: if (txReady) begin
                if (lastSent) begin
                    state_d = ST_FINISH;
                end else if (pixFull) begin
                    txLoad     = 1'b1;
                    txReq.dc   = 1'b1;
                    txReq.data = hiSent ? pixBuf[7:0] : pixBuf[15:8];
                    // Prefetch the next pixel while this low byte shifts out.
                    issueRead  = hiSent && (rdAddr != LAST_ADDR);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busyQ    <= 1'b0;
            csNQ     <= 1'b1;
            yQ       <= '0;
            rdAddr   <= '0;
            byteIdx  <= '0;
            pixBuf   <= '0;
            pixFull  <= 1'b0;
            hiSent   <= 1'b0;
            lastSent <= 1'b0;
            vld_pipe <= '0;
        end else begin
            // Buffer data is valid the cycle after the address, so capture two edges after issue.
            vld_pipe <= {vld_pipe[STAGES-1:0], issueRead};
            if (vld_pipe[STAGES]) begin
                pixBuf  <= bus.readData;
                pixFull <= 1'b1;
            end
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    busyQ    <= 1'b1;
                    csNQ     <= 1'b0;
                    byteIdx  <= '0;
                    hiSent   <= 1'b0;
                    lastSent <= 1'b0;
                    pixFull  <= 1'b0;
                end
                ST_CMD_PAGE:  if (txLoad) byteIdx <= byteIdx + 3'd1;
                ST_CMD_RAMWR: if (txLoad) rdAddr <= '0;
                ST_PIXELS: if (txLoad) begin
                    if (!hiSent) begin
                        hiSent <= 1'b1;
                    end else begin
                        hiSent  <= 1'b0;
                        pixFull <= 1'b0;
                        if (rdAddr == LAST_ADDR) lastSent <= 1'b1;
                        else                     rdAddr   <= rdAddr + 9'd1;
                    end
                end
                ST_FINISH: begin
                    busyQ <= 1'b0;
                    csNQ  <= 1'b1;
                    yQ    <= (yQ == LAST_ROW) ? 9'd0 : yQ + 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_row_streamer.sv
// Directed bench: three streamer instances (main/wrap, slow SCLK, tall frame)
// with SPI byte capture and hand-computed expected byte streams.
module tb_lcd_row_streamer;
    import lcd_pkg::*;

    logic clock = 1'b0;
    logic rstA_n, rstN;
    always #5 clock = ~clock;

    lcd_row_streamer_if ifA ();
    lcd_row_streamer_if ifB ();
    lcd_row_streamer_if ifC ();

    lcd_row_streamer #(.WIDTH(4), .HEIGHT(3),   .CLKDIV(1)) dutA (.clock(clock), .resetN(rstA_n), .bus(ifA));
    lcd_row_streamer #(.WIDTH(4), .HEIGHT(3),   .CLKDIV(3)) dutB (.clock(clock), .resetN(rstN),   .bus(ifB));
    lcd_row_streamer #(.WIDTH(1), .HEIGHT(480), .CLKDIV(1)) dutC (.clock(clock), .resetN(rstN),   .bus(ifC));

    logic [15:0] memA [0:3];
    logic [15:0] memB [0:3];
    logic [7:0]  golden0 [0:13];

    always @(posedge clock) begin
        ifA.readData <= memA[ifA.readAddress[1:0]];
        ifB.readData <= memB[ifB.readAddress[1:0]];
        ifC.readData <= 16'hABCD;
    end

    int nvec = 0, nbad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SPI byte capture for A (mode 0: sample on the rising edge)
    logic [7:0] shA;
    int         nbA = 0, riseA = 0, csRiseA = 0, csBusyA = 0;
    logic [7:0] byA [$];
    logic       dcA [$];
    always @(posedge ifA.lcdSclk or negedge rstA_n) begin
        if (!rstA_n) nbA = 0;
        else begin
            shA = {shA[6:0], ifA.lcdMosi};
            riseA++;
            if (ifA.lcdCsN) csRiseA++;
            nbA++;
            if (nbA == 8) begin
                byA.push_back(shA);
                dcA.push_back(ifA.lcdDc);
                nbA = 0;
            end
        end
    end
    always @(negedge clock) if (ifA.busy && ifA.lcdCsN) csBusyA++;

    logic [7:0] shC;
    int         nbC = 0;
    logic [7:0] byC [$];
    always @(posedge ifC.lcdSclk) begin
        shC = {shC[6:0], ifC.lcdMosi};
        nbC++;
        if (nbC == 8) begin
            byC.push_back(shC);
            nbC = 0;
        end
    end

    // SCLK phase and MOSI stability watcher for B
    logic pSclkB = 1'b0, pMosiB = 1'b0;
    int   hiRunB = 0, loRunB = 100, riseB = 0, badB = 0, lo3B = 0;
    always @(negedge clock) begin
        if (ifB.lcdSclk) begin
            if (ifB.lcdMosi !== pMosiB) badB++;
            if (!pSclkB) begin
                riseB++;
                if (loRunB < 3) badB++;
                if (loRunB == 3) lo3B++;
                hiRunB = 1;
            end else hiRunB++;
        end else begin
            if (pSclkB) begin
                if (hiRunB != 3) badB++;
                loRunB = 1;
            end else loRunB++;
        end
        pSclkB = ifB.lcdSclk;
        pMosiB = ifB.lcdMosi;
    end

    function automatic logic busy_of(input int w);
        case (w)
            0:       return ifA.busy;
            1:       return ifB.busy;
            default: return ifC.busy;
        endcase
    endfunction

    // Called at a negedge; holds start for exactly one rising edge.
    task automatic start_row(input int w);
        case (w)
            0:       ifA.start = 1'b1;
            1:       ifB.start = 1'b1;
            default: ifC.start = 1'b1;
        endcase
        @(negedge clock);
        ifA.start = 1'b0;
        ifB.start = 1'b0;
        ifC.start = 1'b0;
    endtask

    task automatic wait_done(input int w, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!busy_of(w)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk({tag, ".done"}, ok, 1);
    endtask

    task automatic check_rowA(input logic [8:0] y, input int base, input string tag);
        logic [13:0] dcGot;
        logic [7:0]  e;
        chk({tag, ".nbytes"}, byA.size() - base, 14);
        for (int k = 0; k < 14; k++) begin
            if (k >= 1 && k <= 4) e = (k % 2 == 1) ? {7'd0, y[8]} : y[7:0];
            else                  e = golden0[k];
            chk($sformatf("%s.b%0d", tag, k), (base + k < byA.size()) ? {24'd0, byA[base + k]} : 32'hDEAD, {24'd0, e});
            dcGot[k] = (base + k < dcA.size()) ? dcA[base + k] : 1'bx;
        end
        chk({tag, ".dc"}, dcGot, 14'h3FDE);
    endtask

    initial begin
        int   bA, rA, cA;
        logic ok;
        rstA_n = 1'b0; rstN = 1'b0;
        ifA.start = 1'b0; ifB.start = 1'b0; ifC.start = 1'b0;
        memA[0] = 16'hF800; memA[1] = 16'h07E0; memA[2] = 16'h001F; memA[3] = 16'hFFFF;
        memB[0] = 16'hA55A; memB[1] = 16'h0F0F; memB[2] = 16'h8001; memB[3] = 16'h3C3C;
        golden0[0] = 8'h2B; golden0[1] = 8'h00; golden0[2]  = 8'h00; golden0[3]  = 8'h00;
        golden0[4] = 8'h00; golden0[5] = 8'h2C; golden0[6]  = 8'hF8; golden0[7]  = 8'h00;
        golden0[8] = 8'h07; golden0[9] = 8'hE0; golden0[10] = 8'h00; golden0[11] = 8'h1F;
        golden0[12] = 8'hFF; golden0[13] = 8'hFF;
        repeat (3) @(negedge clock);

        chk("rst.busy",  ifA.busy, 0);
        chk("rst.y",     ifA.yCoord, 0);
        chk("rst.raddr", ifA.readAddress, 0);
        chk("rst.csn",   ifA.lcdCsN, 1);
        chk("rst.dc",    ifA.lcdDc, 0);
        chk("rst.sclk",  ifA.lcdSclk, 0);
        chk("rst.mosi",  ifA.lcdMosi, 0);
        rstA_n = 1'b1; rstN = 1'b1;
        @(negedge clock);

        // Row 0: the reference byte stream
        bA = byA.size(); rA = riseA; cA = csRiseA;
        start_row(0);
        chk("row0.busy", ifA.busy, 1);
        chk("row0.csn",  ifA.lcdCsN, 0);
        wait_done(0, "row0");
        check_rowA(9'd0, bA, "row0");
        chk("row0.rises",  riseA - rA, 112);
        chk("row0.csrise", csRiseA - cA, 0);
        chk("row0.csbusy", csBusyA, 0);
        chk("row0.y",      ifA.yCoord, 1);
        chk("row0.csnEnd", ifA.lcdCsN, 1);

        // Back-to-back rows, start in the first idle cycle; HEIGHT=3 wraps to 0
        bA = byA.size();
        start_row(0);
        wait_done(0, "row1");
        check_rowA(9'd1, bA, "row1");
        chk("row1.y", ifA.yCoord, 2);
        bA = byA.size();
        start_row(0);
        wait_done(0, "row2");
        check_rowA(9'd2, bA, "row2");
        chk("row2.y", ifA.yCoord, 0);

        // Start pulses while busy are ignored
        bA = byA.size();
        start_row(0);
        repeat (18) @(negedge clock);
        start_row(0);
        repeat (130) @(negedge clock);
        start_row(0);
        wait_done(0, "ign");
        repeat (300) @(negedge clock);
        check_rowA(9'd0, bA, "ign");
        chk("ign.busy", ifA.busy, 0);
        chk("ign.y",    ifA.yCoord, 1);

        // Reset during pixel 2 aborts; next row restarts at row 0 from PASET
        start_row(0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ifA.readAddress == 9'd2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("abort.reach", ok, 1);
        repeat (20) @(negedge clock);
        #1 rstA_n = 1'b0;
        #1;
        chk("abort.csn",  ifA.lcdCsN, 1);
        chk("abort.sclk", ifA.lcdSclk, 0);
        chk("abort.busy", ifA.busy, 0);
        chk("abort.y",    ifA.yCoord, 0);
        @(negedge clock);
        rstA_n = 1'b1;
        @(negedge clock);
        bA = byA.size();
        start_row(0);
        wait_done(0, "rerow");
        check_rowA(9'd0, bA, "rerow");

        // CLKDIV=3 phase timing
        start_row(1);
        wait_done(1, "slow");
        chk("slow.rises", riseB, 112);
        chk("slow.bad",   badB, 0);
        chk("slow.lo3",   lo3B >= 98, 1);
        chk("slow.y",     ifB.yCoord, 1);

        // Advance C to row 300 and check the 9-bit page parameters
        for (int r = 0; r < 300; r++) begin
            start_row(2);
            wait_done(2, "skipC");
        end
        chk("c.y300", ifC.yCoord, 300);
        bA = byC.size();
        start_row(2);
        wait_done(2, "c300");
        chk("c300.nbytes", byC.size() - bA, 8);
        if (byC.size() >= bA + 5) begin
            chk("c300.b0", byC[bA],     8'h2B);
            chk("c300.b1", byC[bA + 1], 8'h01);
            chk("c300.b2", byC[bA + 2], 8'h2C);
            chk("c300.b3", byC[bA + 3], 8'h01);
            chk("c300.b4", byC[bA + 4], 8'h2C);
        end
        chk("c300.y", ifC.yCoord, 301);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
